imem_loader: RTL and testbench

Boot-time program loader that sequences the instruction-memory write port. It takes a byte stream from the UART receiver, assembles little-endian 32-bit words, and drives the instruction memory's program-load port (`pro_data`, `pro_addr`, `memwrite`). It holds the core in reset until loading finishes, then returns a one-byte status to the UART transmitter.

---
 rtl/imem_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian UART byte stream into 32-bit words and drives
// the instruction-memory load port. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int         MAX_WORDS = 64,
  parameter logic [7:0] ACK_OK    = 8'hAA,
  parameter logic [7:0] ACK_ERR   = 8'hEE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        reload,
  output logic [31:0] pro_data,
  output logic [31:0] pro_addr,
  output logic        memwrite,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_hold,
  output logic        done
);

  localparam int IW = $clog2(MAX_WORDS) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR = 3'd0, S_DATA = 3'd1, S_ACK = 3'd2, S_ERR_ACK = 3'd3,
    S_DONE = 3'd4, S_ERR = 3'd5, S_CSUM = 3'd6
  } state_t;
  localparam state_t END_STATE = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_HDR = 3'd0, S_DATA = 3'd1, S_ACK = 3'd2, S_ERR_ACK = 3'd3,
    S_DONE = 3'd4, S_ERR = 3'd5
  } state_t;
  localparam state_t END_STATE = S_ACK;
`endif

  state_t          state_r;
  state_t          state_next_s;
  logic [1:0]      byte_cnt_r;
  logic [31:0]     count_r;
  logic [31:0]     word_r;
  logic [IW-1:0]   word_idx_r;
  logic [7:0]      csum_r;
  logic [31:0]     pro_data_r;
  logic [31:0]     pro_addr_r;
  logic            memwrite_r;
  logic [7:0]      tx_data_r;
  logic            tx_valid_r;
  logic            cpu_hold_r;
  logic            done_r;

  logic            last_byte_s;
  logic [31:0]     hdr_count_s;
  logic [31:0]     assembled_s;
  logic [IW-1:0]   idx_inc_s;
  logic [31:0]     idx_ext_s;
  logic            last_word_s;
  logic            restart_s;
  logic [7:0]      tx_data_s;
  logic            tx_valid_s;
  logic            cpu_hold_s;
  logic            done_s;

  // Bytes arrive LSB first, so each new byte is shifted in at the top.
  assign last_byte_s = rx_valid && (byte_cnt_r == 2'd3);
  assign hdr_count_s = {rx_data, count_r[31:8]};
  assign assembled_s = {rx_data, word_r[31:8]};
  assign idx_inc_s   = word_idx_r + IW'(1);
  assign idx_ext_s   = 32'(idx_inc_s);
  assign last_word_s = (idx_ext_s == count_r);
  assign restart_s   = reload && ((state_r == S_DONE) || (state_r == S_ERR));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_HDR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_HDR: begin
        if (last_byte_s) begin
          if (hdr_count_s == 32'd0) begin
            state_next_s = END_STATE;
          end else if (hdr_count_s > 32'(MAX_WORDS)) begin
            state_next_s = S_ERR_ACK;
          end else begin
            state_next_s = S_DATA;
          end
        end else begin
          state_next_s = S_HDR;
        end
      end
      S_DATA: begin
        if (last_byte_s && last_word_s) begin
          state_next_s = END_STATE;
        end else begin
          state_next_s = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          state_next_s = (rx_data == csum_r) ? S_ACK : S_ERR_ACK;
        end else begin
          state_next_s = S_CSUM;
        end
      end
`endif
      S_ACK: begin
        if (tx_ready) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_ACK;
        end
      end
      S_ERR_ACK: begin
        if (tx_ready) begin
          state_next_s = S_ERR;
        end else begin
          state_next_s = S_ERR_ACK;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_next_s = S_HDR;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = S_HDR;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    tx_data_s  = 8'd0;
    tx_valid_s = 1'b0;
    cpu_hold_s = 1'b1;
    done_s     = 1'b0;
    case (state_next_s)
      S_ACK: begin
        tx_data_s  = ACK_OK;
        tx_valid_s = 1'b1;
      end
      S_ERR_ACK: begin
        tx_data_s  = ACK_ERR;
        tx_valid_s = 1'b1;
      end
      S_DONE: begin
        cpu_hold_s = 1'b0;
        done_s     = 1'b1;
      end
      default: begin
        tx_data_s  = 8'd0;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      cpu_hold_r <= cpu_hold_s;
      done_r     <= done_s;
    end
  end

  // Byte assembly, word index and load-port write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_r <= 2'd0;
      count_r    <= 32'd0;
      word_r     <= 32'd0;
      word_idx_r <= '0;
      csum_r     <= 8'd0;
      pro_data_r <= 32'd0;
      pro_addr_r <= 32'd0;
      memwrite_r <= 1'b0;
    end else begin
      memwrite_r <= 1'b0;
      if (restart_s) begin
        byte_cnt_r <= 2'd0;
        count_r    <= 32'd0;
        word_idx_r <= '0;
        csum_r     <= 8'd0;
      end else if (rx_valid && (state_r == S_HDR)) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        count_r    <= hdr_count_s;
      end else if (rx_valid && (state_r == S_DATA)) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        word_r     <= assembled_s;
        csum_r     <= csum_r ^ rx_data;
        if (byte_cnt_r == 2'd3) begin
          memwrite_r <= 1'b1;
          pro_data_r <= assembled_s;
          pro_addr_r <= {idx_ext_s[29:0], 2'b00};
          word_idx_r <= idx_inc_s;
        end
      end
    end
  end

  assign pro_data = pro_data_r;
  assign pro_addr = pro_addr_r;
  assign memwrite = memwrite_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign cpu_hold = cpu_hold_r;
  assign done     = done_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and
// popped by a monitor whenever memwrite pulses.
module tb_imem_loader;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;
  logic [31:0] pro_data;
  logic [31:0] pro_addr;
  logic        memwrite;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_hold;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] wq[$];
  logic [7:0]  csum;

  imem_loader dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
    .pro_data(pro_data), .pro_addr(pro_addr), .memwrite(memwrite),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cpu_hold(cpu_hold), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pops one expected {addr,data} per write; a write with nothing queued is an error.
  always @(negedge clk) begin
    if (rstn && memwrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, memwrite}, 64'd0);
      end else begin
        chk("write", {pro_addr, pro_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input bit gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    if (gap) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic put_word(input logic [31:0] w, input int k, input bit gap);
    exp_q.push_back({32'(4 * (k + 1)), w});
    for (int i = 0; i < 4; i++) begin
      put(w[8*i +: 8], gap);
      csum = csum ^ w[8*i +: 8];
    end
  endtask

  task automatic load_words(input bit gap);
    logic [31:0] n;
    n    = 32'(wq.size());
    csum = 8'd0;
    for (int i = 0; i < 4; i++) put(n[8*i +: 8], gap);
    for (int k = 0; k < wq.size(); k++) put_word(wq[k], k, gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    put(csum, gap);
`endif
    rx_valid = 1'b0;
  endtask

  task automatic wait_ack(input logic [7:0] exp, input int hold, input bit ok);
    int n;
    n = 0;
    while (!tx_valid && n < 300) begin
      tick();
      n++;
    end
    chk("tx_valid_rise", tx_valid, 1'b1);
    chk("tx_data", tx_data, exp);
    chk("hold_in_ack", cpu_hold, 1'b1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("tx_valid_stall", tx_valid, 1'b1);
      chk("tx_data_stall", tx_data, exp);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_valid_fall", tx_valid, 1'b0);
    chk("cpu_hold_after", cpu_hold, !ok);
    chk("done_after", done, ok);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("reload_hold", cpu_hold, 1'b1);
    chk("reload_done", done, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_pro_data", pro_data, 32'd0);
    chk("rst_pro_addr", pro_addr, 32'd0);
    chk("rst_memwrite", memwrite, 1'b0);
    chk("rst_tx_data", tx_data, 8'd0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; reload = 1'b0; tx_ready = 1'b0;
    csum = 8'd0;
    repeat (3) tick();
    chk_reset_vals();
    rstn = 1'b1;
    tick();

    // Two-word program
    wq = '{32'h00400513, 32'h008000EF};
    load_words(1'b1);
    wait_ack(8'hAA, 0, 1'b1);
    chk("held_addr", pro_addr, 32'd8);
    chk("held_data", pro_data, 32'h008000EF);
    for (int i = 0; i < 3; i++) put(8'h5A, 1'b0);
    rx_valid = 1'b0;
    tick();
    chk("done_ignores_bytes", done, 1'b1);
    do_reload();

    // Oversized header, then recovery
    put(8'h41, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0);
    rx_valid = 1'b0;
    wait_ack(8'hEE, 0, 1'b0);
    repeat (2) tick();
    chk("err_hold", cpu_hold, 1'b1);
    do_reload();
    wq = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
    load_words(1'b1);
    wait_ack(8'hAA, 0, 1'b1);
    do_reload();

    // Empty program
    wq = '{};
    load_words(1'b0);
    wait_ack(8'hAA, 0, 1'b1);
    for (int i = 0; i < 5; i++) put(8'(i), 1'b0);
    rx_valid = 1'b0;
    tick();
    chk("empty_done", done, 1'b1);
    do_reload();

    // Full memory at full byte rate, then a stalled transmitter
    wq = '{};
    for (int i = 0; i < 64; i++) wq.push_back($urandom());
    load_words(1'b0);
    wait_ack(8'hAA, 10, 1'b1);
    chk("last_addr", pro_addr, 32'd256);
    do_reload();

    // Reset in the middle of the second word
    csum = 8'd0;
    put(8'h02, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0);
    put_word(32'h11223344, 0, 1'b0);
    put(8'hAB, 1'b0); put(8'hCD, 1'b0);
    rx_valid = 1'b0;
    tick();
    chk("pre_reset_data", pro_data, 32'h11223344);
    rstn = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    rstn = 1'b1;
    tick();
    wq = '{32'h12345678};
    load_words(1'b0);
    wait_ack(8'hAA, 0, 1'b1);
    chk("post_reset_addr", pro_addr, 32'd4);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
